// File: rtl/stack_pkg.sv
// Shared constants and helpers for the parameterised LIFO stack.
package stack_pkg;

  localparam int DEF_WIDTH = 32'd8;
  localparam int DEF_DEPTH = 32'd16;

  // Ceiling log2 used for address and occupancy widths.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 32'd0;
    rem    = value - 32'd1;
    while (rem > 32'd0) begin
      result = result + 32'd1;
      rem    = rem >> 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/stack_mem_array.sv
// DEPTH x WIDTH register array: synchronous write port, asynchronous read port.
module stack_mem_array
  import stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage write; contents are never cleared, reset only hides them via count.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/lifo_stack_param.sv
// Parameterised LIFO stack: occupancy tracking, flags and registered pop output.
module lifo_stack_param
  import stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int CW   = clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int            AW      = clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic             we_s;
  logic [AW-1:0]    waddr_s;
  logic [AW-1:0]    raddr_s;
  logic [WIDTH-1:0] rdata_s;
  logic [CW-1:0]    cnt_nxt_s;
  logic             dout_ld_s;
  logic             dout_pass_s;
  logic [WIDTH-1:0] dout_nxt_s;
  logic             valid_nxt_s;
  logic             ovf_nxt_s;
  logic             unf_nxt_s;

  stack_mem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock (clock),
    .we    (we_s & ~reset),
    .waddr (waddr_s),
    .wdata (data_in),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  // The top entry sits one below the occupancy count.
  assign raddr_s    = AW'(count - CW'(1));
  assign dout_nxt_s = dout_pass_s ? data_in : rdata_s;

  // Next-state decode for push/pop combinations.
  always_comb begin
    we_s        = 1'b0;
    waddr_s     = AW'(count);
    cnt_nxt_s   = count;
    dout_ld_s   = 1'b0;
    dout_pass_s = 1'b0;
    valid_nxt_s = 1'b0;
    ovf_nxt_s   = 1'b0;
    unf_nxt_s   = 1'b0;
    case ({push, pop})
      2'b11: begin
        valid_nxt_s = 1'b1;
        dout_ld_s   = 1'b1;
        if (empty) begin
          dout_pass_s = 1'b1;
        end else begin
          we_s    = 1'b1;
          waddr_s = raddr_s;
        end
      end
      2'b10: begin
        if (full) begin
          ovf_nxt_s = 1'b1;
        end else begin
          we_s      = 1'b1;
          cnt_nxt_s = count + CW'(1);
        end
      end
      2'b01: begin
        if (empty) begin
          unf_nxt_s = 1'b1;
        end else begin
          valid_nxt_s = 1'b1;
          dout_ld_s   = 1'b1;
          cnt_nxt_s   = count - CW'(1);
        end
      end
      default: begin
        cnt_nxt_s = count;
      end
    endcase
  end

  // Occupancy count with flags derived from the same next value.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      count <= cnt_nxt_s;
      empty <= (cnt_nxt_s == CW'(0));
      full  <= (cnt_nxt_s == DEPTH_C);
    end
  end

  // Pop data register holds unless a pop is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out <= '0;
    end else if (dout_ld_s) begin
      data_out <= dout_nxt_s;
    end
  end

  // One-cycle status pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_out <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      valid_out <= valid_nxt_s;
      overflow  <= ovf_nxt_s;
      underflow <= unf_nxt_s;
    end
  end

endmodule
